// File: rtl/fc_classifier_param.sv
// fc_classifier_param: parametrised, ready/valid fully-connected classifier.
// Accumulates N_IN signed samples against N_OUT weight rows, re-quantises each
// score (multiply, arithmetic shift, saturate) and reports the arg-max class.
// Optional per-neuron bias is enabled by defining the macro FC_BIAS_EN.
module fc_classifier_param #(
  parameter int DATA_W     = 8,
  parameter int N_IN       = 48,
  parameter int N_OUT      = 10,
  parameter int ACC_W      = 32,
  parameter int MULTIPLIER = 200000,
  parameter int SHIFT      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_last,
  input  logic [DATA_W*N_IN*N_OUT-1:0]  weights_flat,
`ifdef FC_BIAS_EN
  input  logic [ACC_W*N_OUT-1:0]        bias_flat,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(N_OUT)-1:0]      out_class,
  output logic [DATA_W-1:0]             out_score,
  output logic                          frame_err
);

  localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int IDX_W  = $clog2(N_OUT + 1);
  localparam int CLS_W  = $clog2(N_OUT);
  localparam int PROD_W = 2 * DATA_W;
  localparam int P_W    = ACC_W + 32;
  localparam logic signed [31:0]    MULT_C = MULTIPLIER;
  localparam logic signed [P_W-1:0] SAT_HI = P_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [P_W-1:0] SAT_LO = P_W'(-(2 ** (DATA_W - 1)));

  typedef enum logic [2:0] {
    ST_ACCUM = 3'd0,
    ST_DRAIN = 3'd1,
    ST_MUL   = 3'd2,
    ST_CLAMP = 3'd3,
    ST_SCAN  = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [PROD_W-1:0]  prod_q [N_OUT];
  logic signed [PROD_W-1:0]  prod_d [N_OUT];
  logic                      prod_vld_q, prod_vld_d;
  logic                      prod_first_q, prod_first_d;
  logic signed [ACC_W-1:0]   acc_q [N_OUT];
  logic signed [ACC_W-1:0]   acc_d [N_OUT];
  logic signed [P_W-1:0]     p_q [N_OUT];
  logic signed [P_W-1:0]     p_d [N_OUT];
  logic signed [DATA_W-1:0]  s_q [N_OUT];
  logic signed [DATA_W-1:0]  s_d [N_OUT];
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [DATA_W-1:0]  cand_q, cand_d;
  logic signed [DATA_W-1:0]  max_score_q, max_score_d;
  logic [CLS_W-1:0]          max_class_q, max_class_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      accept_s;
  logic                      last_pos_s;

  // Signed sample x weight product.
  function automatic logic signed [PROD_W-1:0] mul_s(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return a * b;
  endfunction

  // Arithmetic shift followed by saturation to the signed output range.
  function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] sh;
    sh = p >>> SHIFT;
    if (sh > SAT_HI) begin
      return SAT_HI[DATA_W-1:0];
    end else if (sh < SAT_LO) begin
      return SAT_LO[DATA_W-1:0];
    end else begin
      return sh[DATA_W-1:0];
    end
  endfunction

  assign accept_s   = in_valid & in_ready_q;
  assign last_pos_s = (cnt_q == CNT_W'(N_IN - 1));

  // Control FSM: frame counting, boundary checking, scan sequencing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_err_d  = 1'b0;
    prod_vld_d   = 1'b0;
    prod_first_d = prod_first_q;
    idx_d        = idx_q;
    cand_d       = cand_q;
    max_score_d  = max_score_q;
    max_class_d  = max_class_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept_s) begin
          prod_first_d = (cnt_q == CNT_W'(0));
          if (last_pos_s) begin
            cnt_d       = CNT_W'(0);
            prod_vld_d  = 1'b1;
            frame_err_d = ~in_last;
            state_d     = ST_DRAIN;
          end else if (in_last) begin
            // Early end of frame: drop the partial frame and this sample.
            cnt_d       = CNT_W'(0);
            prod_vld_d  = 1'b0;
            frame_err_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            prod_vld_d = 1'b1;
          end
        end else begin
          prod_vld_d = 1'b0;
        end
      end
      ST_DRAIN: state_d = ST_MUL;
      ST_MUL:   state_d = ST_CLAMP;
      ST_CLAMP: state_d = ST_SCAN;
      ST_SCAN: begin
        // Registered select of s[idx] feeds the compare one cycle later.
        if (idx_q < IDX_W'(N_OUT)) begin
          cand_d = s_q[idx_q];
        end else begin
          cand_d = cand_q;
        end
        if (idx_q != IDX_W'(0)) begin
          if ((idx_q == IDX_W'(1)) || (cand_q > max_score_q)) begin
            max_score_d = cand_q;
            max_class_d = CLS_W'(idx_q - IDX_W'(1));
          end else begin
            max_score_d = max_score_q;
          end
        end else begin
          max_class_d = max_class_q;
        end
        if (idx_q == IDX_W'(N_OUT)) begin
          idx_d   = IDX_W'(0);
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_OUT);
  end

  // Datapath: product stage, accumulate stage, requant multiply and clamp.
  always_comb begin
    for (int n = 0; n < N_OUT; n++) begin
      prod_d[n] = prod_q[n];
      acc_d[n]  = acc_q[n];
      p_d[n]    = p_q[n];
      s_d[n]    = s_q[n];
      if (accept_s) begin
        prod_d[n] = mul_s($signed(in_data),
                          $signed(weights_flat[(n * N_IN + int'(cnt_q)) * DATA_W +: DATA_W]));
      end else begin
        prod_d[n] = prod_q[n];
      end
      if (prod_vld_q) begin
        if (prod_first_q) begin
`ifdef FC_BIAS_EN
          acc_d[n] = $signed(bias_flat[n * ACC_W +: ACC_W]) + ACC_W'(prod_q[n]);
`else
          acc_d[n] = ACC_W'(prod_q[n]);
`endif
        end else begin
          acc_d[n] = acc_q[n] + ACC_W'(prod_q[n]);
        end
      end else begin
        acc_d[n] = acc_q[n];
      end
      if (state_q == ST_MUL) begin
        p_d[n] = P_W'(acc_q[n]) * P_W'(MULT_C);
      end else begin
        p_d[n] = p_q[n];
      end
      if (state_q == ST_CLAMP) begin
        s_d[n] = sat_shift(p_q[n]);
      end else begin
        s_d[n] = s_q[n];
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      cnt_q        <= CNT_W'(0);
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      idx_q        <= IDX_W'(0);
      cand_q       <= DATA_W'(0);
      max_score_q  <= DATA_W'(0);
      max_class_q  <= CLS_W'(0);
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int n = 0; n < N_OUT; n++) begin
        prod_q[n] <= PROD_W'(0);
        acc_q[n]  <= ACC_W'(0);
        p_q[n]    <= P_W'(0);
        s_q[n]    <= DATA_W'(0);
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prod_vld_q   <= prod_vld_d;
      prod_first_q <= prod_first_d;
      idx_q        <= idx_d;
      cand_q       <= cand_d;
      max_score_q  <= max_score_d;
      max_class_q  <= max_class_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
      p_q          <= p_d;
      s_q          <= s_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = max_class_q;
  assign out_score = max_score_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fc_classifier_param.sv
// Self-checking bench for fc_classifier_param with a behavioural score model.
module tb_fc_classifier_param;
  localparam int DATA_W = 8;
  localparam int N_IN   = 48;
  localparam int N_OUT  = 10;
  localparam int ACC_W  = 32;
  localparam int MULT   = 200000;
  localparam int SHIFT  = 16;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_W-1:0]            in_data;
  logic                         in_last;
  logic [DATA_W*N_IN*N_OUT-1:0] weights_flat;
`ifdef FC_BIAS_EN
  logic [ACC_W*N_OUT-1:0]       bias_flat;
`endif
  logic                         out_valid;
  logic                         out_ready;
  logic [$clog2(N_OUT)-1:0]     out_class;
  logic [DATA_W-1:0]            out_score;
  logic                         frame_err;

  int w_m [N_OUT][N_IN];
  int d_m [N_IN];
  int b_m [N_OUT];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fc_classifier_param #(
    .DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W),
    .MULTIPLIER(MULT), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .weights_flat(weights_flat),
`ifdef FC_BIAS_EN
    .bias_flat(bias_flat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_score(out_score), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_w(input int n, input int k, input int v);
    w_m[n][k] = v;
    weights_flat[(n*N_IN+k)*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  task automatic set_b(input int n, input int v);
`ifdef FC_BIAS_EN
    b_m[n] = v;
    bias_flat[n*ACC_W +: ACC_W] = ACC_W'(v);
`else
    b_m[n] = 0;
`endif
  endtask

  task automatic fill_w(input int lo, input int hi);
    for (int n = 0; n < N_OUT; n++)
      for (int k = 0; k < N_IN; k++)
        set_w(n, k, int'($urandom_range(hi - lo)) + lo);
  endtask

  task automatic fill_d(input int lo, input int hi);
    for (int k = 0; k < N_IN; k++) d_m[k] = int'($urandom_range(hi - lo)) + lo;
  endtask

  // Reference: exact dot products, 32-bit wrap, requant, strict first-max.
  task automatic model(output int cls, output int score);
    int acc, sc, best;
    longint p, sh;
    best = 0;
    cls  = 0;
    for (int n = 0; n < N_OUT; n++) begin
      acc = b_m[n];
      for (int k = 0; k < N_IN; k++) acc += d_m[k] * w_m[n][k];
      p  = longint'(acc) * longint'(MULT);
      sh = p >>> SHIFT;
      sc = (sh > 127) ? 127 : (sh < -128) ? -128 : int'(sh);
      if (n == 0 || sc > best) begin
        best = sc;
        cls  = n;
      end
    end
    score = best;
  endtask

  // last_idx: sample carrying in_last (-1 = none); hold: cycles of out_ready=0;
  // rst_at: if >0, pulse rst that many cycles after the last accept.
  task automatic run_frame(input int last_idx, input int hold, input int rst_at, input string tag);
    int  nsend, exp_cls, exp_score, k;
    logic early, err_exp, bad;
    early   = (last_idx >= 0) && (last_idx < N_IN - 1);
    nsend   = early ? last_idx + 1 : N_IN;
    err_exp = (last_idx != N_IN - 1);
    model(exp_cls, exp_score);
    for (int i = 0; i < nsend; i++) begin
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1);
      if (i > 0) chk({tag, "_ferr_mid"}, frame_err, 0);
      in_valid = 1'b1;
      in_data  = DATA_W'(d_m[i]);
      in_last  = (i == last_idx);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_ferr"}, frame_err, err_exp);
    @(negedge clk);
    chk({tag, "_ferr_end"}, frame_err, 0);
    k = 1;
    if (early) begin
      bad = 1'b0;
      repeat (20) begin
        if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        @(negedge clk);
      end
      chk({tag, "_no_output"}, bad, 0);
    end else if (rst_at > 0) begin
      while (k < rst_at) begin
        @(negedge clk);
        k++;
      end
      chk({tag, "_busy_in_ready"}, in_ready, 0);
      rst = 1'b1;
      #1;
      chk({tag, "_rst_out_valid"}, out_valid, 0);
      chk({tag, "_rst_in_ready"}, in_ready, 1);
      chk({tag, "_rst_class"}, out_class, 0);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      while (out_valid !== 1'b1 && k < 60) begin
        @(negedge clk);
        k++;
      end
      chk({tag, "_latency"}, k, N_OUT + 4);
      chk({tag, "_in_ready_busy"}, in_ready, 0);
      chk({tag, "_class"}, out_class, exp_cls);
      chk({tag, "_score"}, $signed(out_score), exp_score);
      if (hold > 0) begin
        bad = 1'b0;
        repeat (hold) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_class) != exp_cls ||
              int'($signed(out_score)) != exp_score) bad = 1'b1;
        end
        chk({tag, "_hold_stable"}, bad, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_after_hs_valid"}, out_valid, 0);
      chk({tag, "_after_hs_ready"}, in_ready, 1);
    end
  endtask

  task automatic hot3();
    fill_w(0, 0);
    for (int k = 0; k < N_IN; k++) set_w(3, k, 1);
    for (int k = 0; k < N_IN; k++) d_m[k] = 2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    out_ready    = 1'b0;
    weights_flat = '0;
`ifdef FC_BIAS_EN
    bias_flat    = '0;
`endif
    for (int n = 0; n < N_OUT; n++) set_b(n, 0);
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_class", out_class, 0);
    chk("reset_score", out_score, 0);
    chk("reset_ferr", frame_err, 0);
    rst = 1'b0;

    hot3();
    run_frame(N_IN - 1, 0, 0, "hot");

    fill_w(0, 0);
    fill_d(-128, 127);
    run_frame(N_IN - 1, 0, 0, "tie_zero");

    fill_w(-1, -1);
    for (int k = 0; k < N_IN; k++) set_w(5, k, 1);
    for (int k = 0; k < N_IN; k++) d_m[k] = 1;
    run_frame(N_IN - 1, 20, 0, "bp_n5");

    fill_w(-128, 127);
    fill_d(-128, 127);
    run_frame(20, 0, 0, "early");
    hot3();
    run_frame(N_IN - 1, 0, 0, "after_early");

    fill_w(-1, 1);
    fill_d(-1, 1);
    run_frame(-1, 0, 0, "nolast");

    fill_w(-128, 127);
    fill_d(-128, 127);
    run_frame(N_IN - 1, 0, 8, "rst_scan");
    fill_w(-1, 1);
    fill_d(-1, 1);
    run_frame(N_IN - 1, 0, 0, "after_rst");

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hot3();
    run_frame(N_IN - 1, 0, 0, "after_midrst");

    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0) begin
        fill_w(-1, 1);
        fill_d(-1, 1);
      end else begin
        fill_w(-128, 127);
        fill_d(-128, 127);
      end
      run_frame(N_IN - 1, int'($urandom_range(3)), 0, "rand");
    end

    fill_w(0, 0);
    fill_d(-128, 127);
    set_b(7, 10000);
    run_frame(N_IN - 1, 0, 0, "bias");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fc_classifier_param.md
# fc_classifier_param

Parametrised, back-pressured fully-connected classifier. It accepts one flattened feature frame of `N_IN` signed samples and computes `N_OUT` dot products in parallel. Each score is re-quantised (multiply, shift, saturate) and the block then outputs the arg-max class plus its score. It sits after the last pooling/flatten stage as the CNN's final layer. Compared with the fixed 48×10 layer it adds:
- generic sizes;
- ready/valid on both sides;
- frame-boundary checking;
- optional bias.

## Interface
- `DATA_W`, 8: sample, weight and output-score width (signed).
- `N_IN`, 48: samples per frame.
- `N_OUT`, 10: neurons/classes (≥2).
- `ACC_W`, 32: accumulator width (signed).
- `MULTIPLIER`, 200000: requant multiplier (signed 32-bit).
- `SHIFT`, 16: requant arithmetic right shift.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: sample valid.
- `in_ready`, out, 1: block can accept a sample.
- `in_data`, in, DATA_W: signed sample.
- `in_last`, in, 1: marks the final sample of a frame.
- `weights_flat`, in, DATA_W*N_IN*N_OUT: weight for neuron n, input k at bits `[(n*N_IN+k)*DATA_W +: DATA_W]`; static during a frame.
- `bias_flat`, in, ACC_W*N_OUT: present only with `FC_BIAS_EN`; bias for neuron n at `[n*ACC_W +: ACC_W]`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_class`, out, $clog2(N_OUT): arg-max index.
- `out_score`, out, DATA_W: saturated score of the winning class.
- `frame_err`, out, 1: one-cycle pulse on a frame-boundary error.

## Operation
- **States:** ACCUM → DRAIN → MUL → CLAMP → SCAN → OUT → ACCUM.
- **ACCUM**
  - `in_ready=1`; a sample is accepted when `in_valid & in_ready`.
  - Stage 1 registers `in_data*w[n][cnt]` for all n, a signed 2·DATA_W product.
  - Stage 2 adds the sign-extended product into `acc[n]`.
  - On the first sample of a frame the product overwrites `acc[n]` instead of adding.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
  - `cnt` counts 0..N_IN-1.
- **Frame completion:** accepting the sample at `cnt==N_IN-1` moves to DRAIN and resets `cnt` to 0.
  - If `in_last=0` on that sample, `frame_err` pulses but the result is still produced.
- **Early `in_last`:** `in_last=1` with `cnt<N_IN-1` pulses `frame_err`, resets `cnt` and discards the partial frame. The stage-2 add is cancelled and the next sample starts a new frame. The state stays ACCUM.
- **DRAIN:** the final product is accumulated.
- **MUL:** `p[n] = acc[n] * MULTIPLIER`, width ACC_W+32, registered.
- **CLAMP:** `s[n] = sat(p[n] >>> SHIFT)` to the range [−2^(DATA_W−1), 2^(DATA_W−1)−1], registered.
- **SCAN:** one neuron per cycle, n = 0..N_OUT-1.
  - The running max is updated only when `s[n] > max` (strict).
  - Ties therefore resolve to the lowest index.
- **OUT:** `out_valid=1`; `out_class`/`out_score` are held stable until `out_valid & out_ready`, then the state returns to ACCUM.
- `in_ready=0` in every state except ACCUM.

## Timing
- **Reset values:** state ACCUM, `cnt=0`, accumulators 0.
  - Outputs: `in_ready=1`, `out_valid=0`, `out_class=0`, `out_score=0`, `frame_err=0`.
- **Throughput:** one sample per cycle with no bubbles in ACCUM.
- **Latency:** `out_valid` rises on the (N_OUT+4)th rising edge after the edge that accepts the last sample; 14 cycles at default.
- **Fastest next frame:** `out_ready=1` while `out_valid` rises gives handshake that cycle, and `in_ready` is 1 on the following cycle.
- **Frame period:** minimum N_IN+N_OUT+5 cycles.
- **`frame_err`:** asserted for exactly the cycle after the offending accept.
- **`rst` mid-frame or mid-output:**
  - Immediate return to reset values; the in-flight frame and any pending result are lost.
  - The first sample after deassertion is sample 0.
- `weights_flat`/`bias_flat` changes outside ACCUM, DRAIN and MUL do not affect the current result.

## Configuration
- **`FC_BIAS_EN` defined:**
  - `bias_flat` port exists.
  - On the first sample of a frame, `acc[n] = bias[n] + product`.
- **`FC_BIAS_EN` undefined:**
  - No `bias_flat` port.
  - `acc[n] = product` on the first sample.
  - Otherwise identical.

## Test plan
- **Single hot neuron:** defaults; neuron 3 weights all 1, others 0; 48 samples of 2 with `in_last` on sample 47. Expect `acc3=96` → 292 → saturated, giving `out_class=3`, `out_score=127`, `out_valid` 14 cycles after the last accept.
- **Ties:** all weights 0, any data → `out_class=0`, `out_score=0`. Neuron 5 weights 1, others −1, data 1 → `out_class=5`, `out_score=127`, other scores −128.
- **Backpressure:** hold `out_ready=0` for 20 cycles after `out_valid`. Expect `in_ready=0` and class/score stable throughout; raise `out_ready` → one-cycle handshake, then `in_ready=1` next cycle.
- **Frame errors:**
  - `in_last=1` on sample 20 → `frame_err` pulse, no output; a following full single-hot-neuron frame still gives class 3.
  - `in_last=0` on sample 47 → `frame_err` pulse and a normal result.
- **Reset:** assert `rst` during SCAN → `out_valid=0` and `in_ready=1` immediately. A following full frame is correct.
- **`FC_BIAS_EN`:** bias[7]=10000, all weights 0 → `out_class=7`, `out_score=127`. The same stimulus without the macro → `out_class=0`, `out_score=0`.
